// File: rtl/mem_req_pkg.sv
// Shared types for the memory block requester: FSM states, word width, offset helper.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_req_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Byte-offset width of a block of 16-bit words.
    function automatic int blk_off_w(input int block_words);
        return $clog2(block_words) + 1;
    endfunction

endpackage

// File: rtl/mem_beat_timer.sv
// Per-beat hold timer: down-counter reloaded with WAIT_CYCLES-1, last while at zero.
// Latency: last asserts WAIT_CYCLES-1 cycles after load.
// Backpressure: none; load restarts the count unconditionally.
module mem_beat_timer #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WAIT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_block_requester.sv
// Memory initiator: block fills (BLOCK_WORDS beats) and single-word write-through; MEM_REQ_CRITICAL_WORD_FIRST_EN starts fills at the requested word.
// Latency: fill done BLOCK_WORDS*WAIT_CYCLES cycles after accept, write done WAIT_CYCLES cycles after accept.
// Backpressure: req_ready only in IDLE; one request in flight, req_valid ignored while busy.
module mem_block_requester
    import mem_req_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [WORD_W-1:0]              req_wdata,
    output logic                           busy,
    output logic                           fill_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [WORD_W-1:0]              fill_data,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [WORD_W-1:0]              mem_data_in,
    input  logic [WORD_W-1:0]              mem_data_out
);

    localparam int OFF_W = blk_off_w(BLOCK_WORDS);
    localparam int IDX_W = OFF_W - 1;
    localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        beat_q, beat_d;
    logic                    timer_load;
    logic                    beat_end;
    logic                    beat_final;
    logic [IDX_W-1:0]        start_idx;

    assign beat_final = (beat_q == LAST_BEAT);

`ifdef MEM_REQ_CRITICAL_WORD_FIRST_EN
    assign start_idx = req_addr[IDX_W:1];
`else
    assign start_idx = '0;
`endif

    mem_beat_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .last  (beat_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = req_wr ? ST_WRITE : ST_READ;
            ST_READ:  if (beat_end && beat_final) state_d = ST_IDLE;
            ST_WRITE: if (beat_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture and beat advance; the index wraps naturally at IDX_W bits.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        timer_load = 1'b0;
        if (state_q == ST_IDLE && req_valid) begin
            addr_d     = req_addr;
            wdata_d    = req_wdata;
            idx_d      = start_idx;
            beat_d     = '0;
            timer_load = 1'b1;
        end else if (state_q == ST_READ && beat_end && !beat_final) begin
            idx_d      = idx_q + IDX_W'(1);
            beat_d     = beat_q + IDX_W'(1);
            timer_load = 1'b1;
        end
    end

    always_comb begin
        req_ready   = 1'b0;
        busy        = 1'b0;
        fill_valid  = 1'b0;
        fill_idx    = '0;
        fill_data   = '0;
        done        = 1'b0;
        mem_addr    = '0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_data_in = '0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_READ: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                // OR-ing the offset into a cleared base never carries past the block.
                mem_addr   = (addr_q & ~OFF_MASK) | ADDR_WIDTH'({idx_q, 1'b0});
                if (beat_end) begin
                    fill_valid = 1'b1;
                    fill_idx   = idx_q;
                    fill_data  = mem_data_out;
                    done       = beat_final;
                end
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_q & ~BYTE_MASK;
                mem_data_in = wdata_q;
                done        = beat_end;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_block_requester.sv
// Randomized and directed bench for mem_block_requester against a cycle-level reference model.
module tb_mem_block_requester;

    localparam int AW = 16;
    localparam int B  = 8;
    localparam int W  = 4;

`ifdef MEM_REQ_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          busy;
    logic          fill_valid;
    logic [2:0]    fill_idx;
    logic [15:0]   fill_data;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_enable;
    logic          mem_wr;
    logic [15:0]   mem_data_in;
    logic [15:0]   mem_data_out;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_addr[15:1]];

    mem_block_requester #(
        .ADDR_WIDTH  (AW),
        .BLOCK_WORDS (B),
        .WAIT_CYCLES (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .fill_valid   (fill_valid),
        .fill_idx     (fill_idx),
        .fill_data    (fill_data),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".req_ready"},   32'(req_ready),   32'd1);
        check_eq({tag, ".busy"},        32'(busy),        32'd0);
        check_eq({tag, ".mem_enable"},  32'(mem_enable),  32'd0);
        check_eq({tag, ".mem_wr"},      32'(mem_wr),      32'd0);
        check_eq({tag, ".mem_addr"},    32'(mem_addr),    32'd0);
        check_eq({tag, ".mem_data_in"}, 32'(mem_data_in), 32'd0);
        check_eq({tag, ".fill_valid"},  32'(fill_valid),  32'd0);
        check_eq({tag, ".fill_idx"},    32'(fill_idx),    32'd0);
        check_eq({tag, ".fill_data"},   32'(fill_data),   32'd0);
        check_eq({tag, ".done"},        32'(done),        32'd0);
    endtask

    // Entered just after a falling edge with the DUT idle; returns the same way.
    // chain keeps req_valid high through done so the next call's request is taken
    // in the first idle cycle.
    task automatic do_req(input bit wr, input int addr, input int wdata, input bit chain);
        int n, start, base, beat, idx, e_addr;
        bit last;
        check_idle("pre");
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = AW'(addr);
        req_wdata = 16'(wdata);
        @(posedge clk);
        n     = wr ? W : B * W;
        start = CWF ? ((addr >> 1) % B) : 0;
        base  = addr & ~(2 * B - 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            beat = c / W;
            last = ((c % W) == W - 1);
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("req_ready", 32'(req_ready), 32'd0);
            check_eq("mem_enable", 32'(mem_enable), 32'd1);
            if (wr) begin
                check_eq("wr.mem_addr", 32'(mem_addr), 32'(addr & 16'hFFFE));
                check_eq("wr.mem_wr", 32'(mem_wr), 32'd1);
                check_eq("wr.mem_data_in", 32'(mem_data_in), 32'(wdata & 16'hFFFF));
                check_eq("wr.fill_valid", 32'(fill_valid), 32'd0);
                check_eq("wr.done", 32'(done), 32'(last));
            end else begin
                idx    = (start + beat) % B;
                e_addr = base + 2 * idx;
                check_eq("rd.mem_addr", 32'(mem_addr), 32'(e_addr));
                check_eq("rd.mem_wr", 32'(mem_wr), 32'd0);
                check_eq("rd.mem_data_in", 32'(mem_data_in), 32'd0);
                check_eq("rd.fill_valid", 32'(fill_valid), 32'(last));
                check_eq("rd.fill_idx", 32'(fill_idx), last ? 32'(idx) : 32'd0);
                check_eq("rd.fill_data", 32'(fill_data), last ? 32'(ref_mem[e_addr >> 1]) : 32'd0);
                check_eq("rd.done", 32'(done), 32'(last && beat == B - 1));
            end
        end
        if (wr) ref_mem[addr >> 1] = 16'(wdata);
        if (!chain) req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_mid_fill(input int addr);
        check_idle("rst.pre");
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = AW'(addr);
        @(posedge clk);
        repeat (2 * W + 1) @(negedge clk);
        check_eq("rst.busy_before", 32'(busy), 32'd1);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle("rst.async");
        repeat (3) begin
            @(negedge clk);
            check_eq("rst.fill_valid", 32'(fill_valid), 32'd0);
            check_eq("rst.done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst.after");
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        fork
            forever begin
                @(posedge clk);
                if (mem_enable && mem_wr) mem[mem_addr[15:1]] = mem_data_in;
            end
        join_none

        #1 check_idle("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        do_req(1'b0, 16'h0036, 0, 1'b0);
        do_req(1'b1, 16'h1235, 16'hBEEF, 1'b0);
        do_req(1'b0, 16'h1230, 0, 1'b1);
        do_req(1'b0, 16'hFFF2, 0, 1'b1);
        do_req(1'b0, 16'h003A, 0, 1'b0);
        reset_mid_fill(16'h0200);
        do_req(1'b0, 16'h0206, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            bit r_wr;
            int r_addr;
            r_wr   = ($urandom_range(0, 2) == 0);
            r_addr = (k % 6 == 5) ? int'($urandom_range(16'hFFF0, 16'hFFFF))
                                  : int'($urandom_range(0, 16'hFFFF));
            do_req(r_wr, r_addr, int'($urandom_range(0, 16'hFFFF)),
                   (k != 23) && ($urandom_range(0, 1) == 1));
        end
        check_idle("end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
